elevator_shaft_model: RTL

Cycle-accurate model of the elevator cabin and shaft for five floors. It consumes the motor command AC (and Open) produced by the elevator controller and drives the floor-alignment sensors S1..S5 back to it, closing the loop for system-level simulation. It tracks cabin position with a per-span travel timer and flags illegal motor commands as a sticky fault.

---
 rtl/elevator_shaft_model.sv | 130 +++++++++++++
 1 files changed

// File: rtl/elevator_shaft_model.sv
// Five-floor elevator cabin/shaft model: follows the controller's motor command, drives the floor sensors back, latches illegal commands.
// Optional door interlock: define ELEVATOR_SHAFT_DOOR_INTERLOCK_EN to fault on Open while departing or moving.
module elevator_shaft_model #(
  parameter int TRAVEL_CYCLES = 3,
  parameter int START_FLOOR   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] AC,
  input  logic       Open,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       S4,
  output logic       S5,
  output logic [2:0] POS,
  output logic       Moving,
  output logic       Fault
);

  typedef enum logic [1:0] {
    AT_FLOOR,
    MOVE_UP,
    MOVE_DOWN,
    FAULT
  } state_t;

  localparam logic [7:0] SPAN_LOAD = 8'(TRAVEL_CYCLES - 1);
  localparam logic [2:0] POS_RESET = 3'(START_FLOOR);

  state_t     state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic [7:0] cnt_q, cnt_d;

  logic cmd_up, cmd_down, door_open;

  assign cmd_up   = (AC == 2'b01);
  assign cmd_down = (AC == 2'b10);

`ifdef ELEVATOR_SHAFT_DOOR_INTERLOCK_EN
  assign door_open = Open;
`else
  // Without the interlock the door command has no effect on the cabin.
  logic unused_open;
  assign unused_open = Open;
  assign door_open   = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= AT_FLOOR;
      pos_q   <= POS_RESET;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first keep every branch fully assigned, so no latches are inferred.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      AT_FLOOR: begin
        if ((cmd_up || cmd_down) && door_open) begin
          state_d = FAULT;
        end else if (cmd_up) begin
          if (pos_q == 3'd5) begin
            state_d = FAULT;
          end else begin
            state_d = MOVE_UP;
            cnt_d   = SPAN_LOAD;
          end
        end else if (cmd_down) begin
          if (pos_q == 3'd1) begin
            state_d = FAULT;
          end else begin
            state_d = MOVE_DOWN;
            cnt_d   = SPAN_LOAD;
          end
        end
      end
      MOVE_UP: begin
        // Reversal outranks arrival on the same edge.
        if (cmd_down || door_open) begin
          state_d = FAULT;
        end else if (cnt_q == 8'd0) begin
          state_d = AT_FLOOR;
          pos_d   = pos_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      MOVE_DOWN: begin
        if (cmd_up || door_open) begin
          state_d = FAULT;
        end else if (cnt_q == 8'd0) begin
          state_d = AT_FLOOR;
          pos_d   = pos_q - 3'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  logic at_floor;
  assign at_floor = (state_q == AT_FLOOR);

  assign S1     = at_floor && (pos_q == 3'd1);
  assign S2     = at_floor && (pos_q == 3'd2);
  assign S3     = at_floor && (pos_q == 3'd3);
  assign S4     = at_floor && (pos_q == 3'd4);
  assign S5     = at_floor && (pos_q == 3'd5);
  assign POS    = pos_q;
  assign Moving = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign Fault  = (state_q == FAULT);

endmodule
